// File: rtl/mem_writeback.sv
// Memory/writeback stage: req/ack data bus with byte/half/word lane handling and a stall for fetch.
// Optional MISALIGN_TRAP_EN: misaligned half/word accesses skip the bus and raise sticky misalign_err.
module mem_writeback #(
    parameter int DATA_WIDTH = 32,
    parameter int TIMEOUT    = 255
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [DATA_WIDTH-1:0] ALUResult,
    input  logic [DATA_WIDTH-1:0] WriteData,
    input  logic [DATA_WIDTH-1:0] PCPlus4,
    input  logic [1:0]            ResultSrc,
    input  logic                  MemWrite,
    input  logic [2:0]            funct3,
    input  logic                  RegWriteIn,
    output logic                  mem_req,
    output logic                  mem_we,
    output logic [DATA_WIDTH-1:0] mem_addr,
    output logic [DATA_WIDTH-1:0] mem_wdata,
    output logic [3:0]            mem_wstrb,
    input  logic                  mem_ack,
    input  logic [DATA_WIDTH-1:0] mem_rdata,
    output logic [DATA_WIDTH-1:0] Result,
    output logic                  RegWrite,
    output logic                  stall,
    output logic                  bus_err
`ifdef MISALIGN_TRAP_EN
    ,
    output logic                  misalign_err
`endif
);

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] BUSY = 2'd1;
    localparam logic [1:0] DONE = 2'd2;

    localparam logic [15:0] TIMEOUT_LAST = 16'(TIMEOUT - 1);

    logic [1:0]  state;
    logic [15:0] cnt;
    logic [31:0] load_data;
    logic [2:0]  f3_q;
    logic [1:0]  off_q;
    logic        trap_q;
    logic        memop;
    logic        misalign;
    logic [31:0] st_wdata;
    logic [3:0]  st_wstrb;
    logic [31:0] alu_val;

    assign memop   = MemWrite | (ResultSrc == 2'b01);
    assign mem_req = (state == BUSY);
    assign alu_val = (ResultSrc == 2'b10) ? PCPlus4 : ALUResult;

`ifdef MISALIGN_TRAP_EN
    always_comb begin
        misalign = 1'b0;
        if (funct3[1:0] == 2'b01)
            misalign = ALUResult[0];
        else if (funct3[1:0] != 2'b00)
            misalign = (ALUResult[1:0] != 2'b00);
    end
`else
    assign misalign = 1'b0;
`endif

    always_comb begin
        st_wdata = WriteData;
        st_wstrb = 4'b1111;
        case (funct3)
            3'b000: begin
                st_wdata = {4{WriteData[7:0]}};
                st_wstrb = 4'b0001 << ALUResult[1:0];
            end
            3'b001: begin
                st_wdata = {2{WriteData[15:0]}};
                st_wstrb = 4'b0011 << {ALUResult[1], 1'b0};
            end
            default: ;
        endcase
    end

    function automatic logic [31:0] fmt_load(input logic [31:0] d, input logic [2:0] f3,
                                             input logic [1:0] off);
        logic [7:0]  b;
        logic [15:0] h;
        b = d[{off, 3'b000} +: 8];
        h = off[1] ? d[31:16] : d[15:0];
        case (f3)
            3'b000:  fmt_load = {{24{b[7]}}, b};
            3'b100:  fmt_load = {24'd0, b};
            3'b001:  fmt_load = {{16{h[15]}}, h};
            3'b101:  fmt_load = {16'd0, h};
            default: fmt_load = d;
        endcase
    endfunction

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            cnt       <= '0;
            load_data <= '0;
            f3_q      <= '0;
            off_q     <= '0;
            trap_q    <= 1'b0;
            mem_we    <= 1'b0;
            mem_addr  <= '0;
            mem_wdata <= '0;
            mem_wstrb <= '0;
            bus_err   <= 1'b0;
`ifdef MISALIGN_TRAP_EN
            misalign_err <= 1'b0;
`endif
        end else begin
            case (state)
                IDLE: begin
                    if (memop) begin
                        f3_q  <= funct3;
                        off_q <= ALUResult[1:0];
                        cnt   <= '0;
                        if (misalign) begin
                            // Trapped access never reaches the bus; DONE forces Result/RegWrite low.
                            state     <= DONE;
                            trap_q    <= 1'b1;
                            load_data <= '0;
`ifdef MISALIGN_TRAP_EN
                            misalign_err <= 1'b1;
`endif
                        end else begin
                            state     <= BUSY;
                            trap_q    <= 1'b0;
                            mem_we    <= MemWrite;
                            mem_addr  <= {ALUResult[31:2], 2'b00};
                            mem_wdata <= st_wdata;
                            mem_wstrb <= st_wstrb;
                        end
                    end
                end
                BUSY: begin
                    if (mem_ack) begin
                        load_data <= fmt_load(mem_rdata, f3_q, off_q);
                        cnt       <= '0;
                        state     <= DONE;
                    end else if (cnt == TIMEOUT_LAST) begin
                        bus_err   <= 1'b1;
                        load_data <= '0;
                        cnt       <= '0;
                        state     <= DONE;
                    end else begin
                        cnt <= cnt + 16'd1;
                    end
                end
                DONE: begin
                    state  <= IDLE;
                    trap_q <= 1'b0;
                end
                default: state <= IDLE;
            endcase
        end
    end

    always_comb begin
        Result   = alu_val;
        RegWrite = 1'b0;
        stall    = 1'b0;
        case (state)
            IDLE: begin
                stall    = memop;
                RegWrite = RegWriteIn & ~memop;
            end
            BUSY: stall = 1'b1;
            DONE: begin
                if (trap_q)
                    Result = '0;
                else if (ResultSrc == 2'b01)
                    Result = load_data;
                RegWrite = RegWriteIn & ~trap_q;
            end
            default: ;
        endcase
    end

endmodule

// File: doc/mem_writeback.md
Name: mem_writeback

Overview:
- Memory/writeback stage. Consumes the execute-stage outputs (ALUResult, WriteData) and returns the writeback value (Result, RegWrite) to the register file.
- Drives a variable-latency req/ack data-memory bus. Handles byte/half/word loads and stores with lane alignment and sign/zero extension.
- Asserts stall to freeze PC/fetch while a memory access is outstanding.

Parameters:
- DATA_WIDTH, 32, datapath width (fixed at 32 for lane logic)
- TIMEOUT, 255, max cycles waiting for mem_ack before bus error (1..65535)

Ports:
- clk  input  1  clock, rising edge
- rst_n  input  1  asynchronous active-low reset
- ALUResult  input  32  effective address / ALU value
- WriteData  input  32  store data (rs2)
- PCPlus4  input  32  return address for JAL/JALR
- ResultSrc  input  2  00 ALU, 01 memory, 10 PCPlus4, 11 reserved (=ALU)
- MemWrite  input  1  store instruction
- funct3  input  3  access size/sign
- RegWriteIn  input  1  decoder register-write enable
- mem_req  output  1  bus request, held until ack
- mem_we  output  1  1=write
- mem_addr  output  32  word-aligned address {ALUResult[31:2],2'b00}
- mem_wdata  output  32  lane-replicated store data
- mem_wstrb  output  4  byte enables
- mem_ack  input  1  one-cycle completion pulse
- mem_rdata  input  32  read data, valid with mem_ack
- Result  output  32  writeback value to register file WD3
- RegWrite  output  1  writeback enable to register file WE3
- stall  output  1  hold PC/fetch this cycle
- bus_err  output  1  sticky timeout flag

Behaviour:
- Reset (async, rst_n=0): state IDLE; mem_req=0; mem_we=0; latched load data=0; timeout counter=0; bus_err=0. rst_n low mid-access drops mem_req immediately, abandons the access, and writes nothing back.
- memop = MemWrite | (ResultSrc==01).
- FSM IDLE -> BUSY -> DONE -> IDLE:
  - IDLE, memop=0: Result combinational per ResultSrc; RegWrite=RegWriteIn; stall=0; zero added latency.
  - IDLE, memop=1: stall=1 and RegWrite=0 (combinational); next state BUSY.
  - BUSY: mem_req=1; mem_we/addr/wdata/wstrb registered on IDLE->BUSY and stable until ack; stall=1; RegWrite=0; counter increments each cycle.
  - BUSY, mem_ack=1: latch formatted mem_rdata (loads); clear counter; next DONE.
  - BUSY, counter reaches TIMEOUT without ack: drop mem_req; set bus_err (sticky until reset); latched data=0; next DONE.
  - DONE: stall=0; Result = latched load data if load, else ALU per ResultSrc; RegWrite=RegWriteIn (stores: 0 from decode); next IDLE.
- Access latency: 1 + ack latency + 1 cycles; minimum 3 cycles with ack on the first BUSY cycle.
- A mem_ack outside BUSY is ignored.
- Store lanes, off = ALUResult[1:0]:
  - SB: wdata={4{WriteData[7:0]}}, wstrb=0001<<off.
  - SH: wdata={2{WriteData[15:0]}}, wstrb=0011<<(2*off[1]).
  - SW and other funct3: wdata=WriteData, wstrb=1111.
- Load extract:
  - LB/LBU (000/100): byte at lane off.
  - LH/LHU (001/101): half at lane off[1].
  - LW and 011/110/111: full word.
  - 000/001 sign-extend; 100/101 zero-extend.

Optional Feature:
- MISALIGN_TRAP_EN
  - Defined: halfword with off[0]=1, or word with off!=0, issues no bus request. The access completes IDLE->DONE in 2 cycles with Result=0 and RegWrite=0. Adds output misalign_err, sticky, cleared by reset.
  - Undefined: no misalign_err port. Low address bits are ignored for lane selection beyond the size rule, so the access is performed on the aligned lanes.

Test Plan:
- ResultSrc=00, ALUResult=0x0000_1234, RegWriteIn=1 -> same cycle Result=0x1234, RegWrite=1, stall=0, mem_req=0.
- LB (funct3=000), ALUResult=0x103, ack after 2 BUSY cycles with rdata=0x80AA_BBCC -> mem_addr=0x100; stall high 3 cycles; DONE Result=0xFFFF_FF80, RegWrite=1.
- LHU (funct3=101), ALUResult=0x202, immediate ack with rdata=0xBEEF_0000 -> Result=0x0000_BEEF, 3-cycle total.
- SB, ALUResult=0x301, WriteData=0x0000_00A5 -> mem_we=1, wstrb=0010, wdata=0xA5A5_A5A5, RegWrite=0 throughout.
- Load with no ack, TIMEOUT=4 -> mem_req drops after 4 BUSY cycles; bus_err=1; DONE Result=0; bus_err stays 1 until rst_n=0.
- rst_n pulsed low during BUSY -> mem_req=0 asynchronously; state IDLE; no RegWrite pulse; next instruction executes normally.
